// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder that processes one 4-bit nibble per cycle,
// least significant nibble first, through a 4-bit carry-lookahead slice.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
module nibble_serial_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] operand1_i,
   input  logic [WIDTH-1:0] operand2_i,
   input  logic             carry_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic             overflow_o
`endif
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned IW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] op1_r, op2_r, sum_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic             last_c;
   logic [IW-1:0]    base_c;
   logic [3:0]       nib_a_c, nib_b_c, nib_g_c, nib_p_c, nib_s_c;
   logic [4:0]       nib_cy_c;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
   logic             ovf_r;
`endif

   assign last_c = (cnt_r == CW'(N - 1));
   assign base_c = IW'({cnt_r, 2'b00});

   // Select the current nibble and add it with the registered carry (4-bit CLA)
   always_comb begin
      nib_a_c     = op1_r[base_c +: 4];
      nib_b_c     = op2_r[base_c +: 4];
      nib_g_c     = nib_a_c & nib_b_c;
      nib_p_c     = nib_a_c ^ nib_b_c;
      nib_cy_c[0] = carry_r;
      nib_cy_c[1] = nib_g_c[0] | (nib_p_c[0] & carry_r);
      nib_cy_c[2] = nib_g_c[1] | (nib_p_c[1] & nib_g_c[0])
                  | (&nib_p_c[1:0] & carry_r);
      nib_cy_c[3] = nib_g_c[2] | (nib_p_c[2] & nib_g_c[1])
                  | (&nib_p_c[2:1] & nib_g_c[0]) | (&nib_p_c[2:0] & carry_r);
      nib_cy_c[4] = nib_g_c[3] | (nib_p_c[3] & nib_g_c[2])
                  | (&nib_p_c[3:2] & nib_g_c[1]) | (&nib_p_c[3:1] & nib_g_c[0])
                  | (&nib_p_c[3:0] & carry_r);
      nib_s_c     = nib_p_c ^ nib_cy_c[3:0];
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_i) state_nxt = RUN;
         RUN:     if (last_c)  state_nxt = DONE;
         DONE:    if (ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture and nibble-serial accumulation
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op1_r   <= '0;
         op2_r   <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cnt_r   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
         ovf_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  op1_r   <= operand1_i;
                  op2_r   <= operand2_i;
                  carry_r <= carry_i;
                  cnt_r   <= '0;
                  sum_r   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                  ovf_r   <= 1'b0;
`endif
               end
            end
            RUN: begin
               sum_r[base_c +: 4] <= nib_s_c;
               carry_r            <= nib_cy_c[4];
               if (!last_c) cnt_r <= cnt_r + CW'(1);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
               if (last_c) ovf_r <= nib_cy_c[3] ^ nib_cy_c[4];
`endif
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; result fields forced to zero outside DONE
   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);
   assign sum_o   = valid_o ? sum_r : '0;
   assign carry_o = valid_o & carry_r;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
   assign overflow_o = valid_o & ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=32): directed cases plus
// randomized operands with random downstream backpressure.
module tb_nibble_serial_adder;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N     = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             valid_i = 1'b0;
   logic             ready_o;
   logic [WIDTH-1:0] operand1_i = '0;
   logic [WIDTH-1:0] operand2_i = '0;
   logic             carry_i = 1'b0;
   logic             valid_o;
   logic             ready_i = 1'b0;
   logic [WIDTH-1:0] sum_o;
   logic             carry_o;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
   logic             overflow_o;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;   // 0: ready_i low, 1: high, 2: random

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .operand1_i (operand1_i),
      .operand2_i (operand2_i),
      .carry_i    (carry_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .sum_o      (sum_o),
      .carry_o    (carry_o)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ,
      .overflow_o (overflow_o)
`endif
   );

   always #5 clk = ~clk;

   // Reference: plain wide addition with signed overflow from operand signs
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
      exp_t e;
      logic [WIDTH:0] full;
      full    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
      e.sum   = full[WIDTH-1:0];
      e.carry = full[WIDTH];
      e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Downstream ready driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       ready_i = 1'b0;
         1:       ready_i = 1'b1;
         default: ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compare on retirement, require zeroed outputs while not valid
   always @(negedge clk) begin
      if (!rst_i) begin
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum_o);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sum", 64'(sum_o), 64'(e.sum));
               check("carry", 64'(carry_o), 64'(e.carry));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
               check("overflow", 64'(overflow_o), 64'(e.ovf));
`endif
            end
         end else if (!valid_o) begin
            check("idle_zero", 64'({carry_o, sum_o}), 64'(0));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            check("idle_ovf_zero", 64'(overflow_o), 64'(0));
`endif
         end
      end
   end

   // Present an operation and hold it until the handshake edge; call just after a posedge
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      bit hs;
      operand1_i = a;
      operand2_i = b;
      carry_i    = c;
      valid_i    = 1'b1;
      hs         = 1'b0;
      for (int n = 0; n < 300 && !hs; n++) begin
         hs = ready_o;
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      if (hs) exp_q.push_back(model(a, b, c));
      else begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: got ready_o=0 expected 1 within 300 cycles");
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      exp_t e;

      // Reset
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      check("rst_ready", 64'(ready_o), 64'(1));
      check("rst_valid", 64'(valid_o), 64'(0));
      check("rst_sum", 64'(sum_o), 64'(0));
      check("rst_carry", 64'(carry_o), 64'(0));

      // Latency: valid_o appears after N+1 edges counted from the handshake edge
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
      repeat (N - 1) @(posedge clk);
      @(negedge clk);
      check("latency_early", 64'(valid_o), 64'(0));
      @(posedge clk);
      @(negedge clk);
      check("latency_valid", 64'(valid_o), 64'(1));
      rdy_mode = 1;
      drain();

      // ready_i high: valid_o lasts one cycle, ready_o returns the next
      issue(32'h0000_0012, 32'h0000_0034, 1'b1);
      repeat (N) @(posedge clk);
      @(negedge clk);
      check("pulse_valid_hi", 64'(valid_o), 64'(1));
      @(posedge clk);
      @(negedge clk);
      check("pulse_valid_lo", 64'(valid_o), 64'(0));
      check("pulse_ready_back", 64'(ready_o), 64'(1));
      @(posedge clk);
      #1;

      // Full carry ripple and signed overflow cases
      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      drain();
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      drain();
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      drain();

      // Backpressure: result held, new request ignored
      @(negedge clk);
      rdy_mode = 0;
      @(posedge clk);
      #1;
      issue(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
      e = model(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
      repeat (N) @(posedge clk);
      #1;
      operand1_i = 32'h1111_1111;
      operand2_i = 32'h2222_2222;
      carry_i    = 1'b1;
      valid_i    = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 64'(valid_o), 64'(1));
         check("bp_ready", 64'(ready_o), 64'(0));
         check("bp_sum", 64'(sum_o), 64'(e.sum));
         check("bp_carry", 64'(carry_o), 64'(e.carry));
      end
      valid_i  = 1'b0;
      rdy_mode = 1;
      drain();
      repeat (N + 3) begin
         @(negedge clk);
         check("bp_no_second", 64'(valid_o), 64'(0));
      end
      @(posedge clk);
      #1;

      // Reset during the third RUN cycle aborts the operation
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_ready", 64'(ready_o), 64'(1));
      check("abort_valid", 64'(valid_o), 64'(0));
      check("abort_sum", 64'(sum_o), 64'(0));
      @(posedge clk);
      #1;
      issue(32'h0000_0001, 32'h0000_0001, 1'b0);
      drain();

      // Randomized operands with random downstream readiness
      @(negedge clk);
      rdy_mode = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] a, b;
         case ($urandom_range(0, 3))
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'h7FFF_FFFF;
            2:       a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? ~a : WIDTH'($urandom);
         issue(a, b, 1'($urandom_range(0, 1)));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
